// File: rtl/application_rmw_if.sv
// Signal bundle between the read-modify-write application and its node interface (NANCI).
// The application drives requests and status; the node side drives runnable and responses.
interface application_rmw_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 10
);
   localparam int MSG_W = ADDR_WIDTH + DATA_WIDTH + 1;

   // Handshake: nanci_result = {valid, addr, data} and app_request = {write, addr, data}.
   // There is no ready/backpressure in either direction. A response counts only in a runnable
   // cycle where valid=1 and addr matches the outstanding target; otherwise it is dropped.
   // A request is live for the cycle it is registered; all-zero means "no request".
   logic             runnable;
   logic [MSG_W-1:0] nanci_result;
   logic [MSG_W-1:0] app_request;
   logic [13:0]      compute_cycles;
   logic             done;
   logic [7:0]       iter_count;
   logic [2:0]       state_dbg;
   logic [7:0]       timeout_dbg;

   modport master (
      input  runnable,
      input  nanci_result,
      output app_request,
      output compute_cycles,
      output done,
      output iter_count,
      output state_dbg,
      output timeout_dbg
   );

   modport slave (
      output runnable,
      output nanci_result,
      input  app_request,
      input  compute_cycles,
      input  done,
      input  iter_count,
      input  state_dbg,
      input  timeout_dbg
   );
endinterface

// File: rtl/application_rmw.sv
// Read-modify-write traffic generator: reads a remote node, increments the value and writes it
// back, ITERS times, walking the target address by a MODE-dependent step.
module application_rmw #(
   parameter int N              = 1024,
   parameter int I              = 0,
   parameter int DATA_WIDTH     = 10,
   parameter int ADDR_WIDTH     = 10,
   parameter int MODE           = 0,
   parameter int STRIDE         = 1,
   parameter int ITERS          = 4,
   parameter int TIMEOUT        = 64,
   parameter int COMPUTE_CYCLES = 5
) (
   input logic               clk,
   input logic               rst,
   application_rmw_if.master bus
);
   localparam int MSG_W = ADDR_WIDTH + DATA_WIDTH + 1;

   localparam int INIT_TARGET_I = (MODE == 0) ? (N - 1 - I) :
                                  (MODE == 1) ? ((I + 1) % N) : ((I + STRIDE) % N);
   localparam int STEP_I        = (MODE == 0) ? 0 : (MODE == 1) ? 1 : STRIDE;

   localparam logic [ADDR_WIDTH-1:0] INIT_TARGET = ADDR_WIDTH'(INIT_TARGET_I);
   localparam logic [ADDR_WIDTH:0]   STEP        = (ADDR_WIDTH + 1)'(STEP_I);
   localparam logic [ADDR_WIDTH:0]   N_W         = (ADDR_WIDTH + 1)'(N);
   localparam logic [8:0]            TMO_LIMIT   = 9'(TIMEOUT - 1);
   localparam logic [7:0]            ITERS_W     = 8'(ITERS);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD_ISSUE = 3'd1,
      ST_RD_WAIT  = 3'd2,
      ST_WR_ISSUE = 3'd3,
      ST_DONE     = 3'd4
   } state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] target;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [7:0]            tmo_cnt;
   logic [7:0]            iter_cnt;
   logic [MSG_W-1:0]      app_req;
   logic                  done_r;

   logic                  rsp_valid;
   logic [ADDR_WIDTH-1:0] rsp_addr;
   logic [DATA_WIDTH-1:0] rsp_data;
   logic                  accept;
   logic [ADDR_WIDTH:0]   target_sum;
   logic [ADDR_WIDTH-1:0] target_next;
   logic [8:0]            tmo_inc;
   logic                  tmo_hit;
   logic [7:0]            iter_inc;

   assign rsp_valid = bus.nanci_result[MSG_W-1];
   assign rsp_addr  = bus.nanci_result[MSG_W-2 -: ADDR_WIDTH];
   assign rsp_data  = bus.nanci_result[DATA_WIDTH-1:0];
   assign accept    = rsp_valid && (rsp_addr == target);

   // One extra bit so target+step cannot overflow before the wrap compare against N.
   assign target_sum  = {1'b0, target} + STEP;
   assign target_next = (target_sum >= N_W) ? ADDR_WIDTH'(target_sum - N_W)
                                            : target_sum[ADDR_WIDTH-1:0];

   assign tmo_inc  = {1'b0, tmo_cnt} + 9'd1;
   assign tmo_hit  = (tmo_inc >= TMO_LIMIT);
   assign iter_inc = iter_cnt + 8'd1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= ST_IDLE;
         target   <= INIT_TARGET;
         rd_data  <= '0;
         tmo_cnt  <= '0;
         iter_cnt <= '0;
         app_req  <= '0;
         done_r   <= 1'b0;
      end else if (bus.runnable) begin
         unique case (state)
            ST_IDLE: begin
               app_req <= '0;
               state   <= ST_RD_ISSUE;
            end
            ST_RD_ISSUE: begin
               app_req <= {1'b0, target, {DATA_WIDTH{1'b0}}};
               tmo_cnt <= '0;
               state   <= ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
               app_req <= '0;
               // Acceptance is checked first so a response in the timeout cycle still wins.
               if (accept) begin
                  rd_data <= rsp_data;
                  state   <= ST_WR_ISSUE;
               end else begin
                  tmo_cnt <= tmo_inc[7:0];
                  if (tmo_hit) state <= ST_RD_ISSUE;
               end
            end
            ST_WR_ISSUE: begin
               app_req  <= {1'b1, target, rd_data + DATA_WIDTH'(1)};
               iter_cnt <= iter_inc;
               target   <= target_next;
               if (iter_inc == ITERS_W) begin
                  state  <= ST_DONE;
                  done_r <= 1'b1;
               end else begin
                  state  <= ST_RD_ISSUE;
               end
            end
            ST_DONE: begin
               app_req <= '0;
               done_r  <= 1'b1;
            end
            default: begin
               app_req <= '0;
               state   <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.app_request    = app_req;
   assign bus.compute_cycles = 14'(COMPUTE_CYCLES);
   assign bus.done           = done_r;
   assign bus.iter_count     = iter_cnt;
   assign bus.state_dbg      = state;
   assign bus.timeout_dbg    = tmo_cnt;
endmodule

// File: tb/tb_application_rmw.sv
// Bench for application_rmw: a directed/randomized main instance (stride pattern, short timeout)
// plus three auto-answered instances covering the opposite, ring and stride target patterns.
module tb_application_rmw;
   localparam int MA = 3;
   localparam int MD = 10;
   localparam int MW = MA + MD + 1;
   localparam int M_N = 8;
   localparam int M_I = 2;
   localparam int M_STRIDE = 3;
   localparam int M_ITERS = 6;
   localparam int M_TIMEOUT = 4;
   localparam int M_CC = 9;
   localparam int AA = 10;
   localparam int AD = 10;
   localparam int AW = AA + AD + 1;

   logic clk;
   logic rst_m;
   logic rst_a;
   int   n_checks;
   int   n_fail;

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- DUTs ----------------
   application_rmw_if #(.ADDR_WIDTH(MA), .DATA_WIDTH(MD)) m_if ();
   application_rmw #(.N(M_N), .I(M_I), .DATA_WIDTH(MD), .ADDR_WIDTH(MA), .MODE(2),
      .STRIDE(M_STRIDE), .ITERS(M_ITERS), .TIMEOUT(M_TIMEOUT), .COMPUTE_CYCLES(M_CC))
      u_dut (.clk(clk), .rst(rst_m), .bus(m_if));

   application_rmw_if #(.ADDR_WIDTH(AA), .DATA_WIDTH(AD)) a0_if ();
   application_rmw_if #(.ADDR_WIDTH(AA), .DATA_WIDTH(AD)) a1_if ();
   application_rmw_if #(.ADDR_WIDTH(AA), .DATA_WIDTH(AD)) a2_if ();
   application_rmw #(.N(1024), .I(3), .MODE(0), .ITERS(4))
      u_a0 (.clk(clk), .rst(rst_a), .bus(a0_if));
   application_rmw #(.N(8), .I(7), .MODE(1), .ITERS(3))
      u_a1 (.clk(clk), .rst(rst_a), .bus(a1_if));
   application_rmw #(.N(8), .I(5), .MODE(2), .STRIDE(3), .ITERS(4))
      u_a2 (.clk(clk), .rst(rst_a), .bus(a2_if));

   logic          a_run;
   logic [AW-1:0] a_rsp  [3];
   logic [AW-1:0] a_req  [3];
   logic          a_done [3];
   logic [7:0]    a_iter [3];
   logic [13:0]   a_cc   [3];

   assign a0_if.runnable = a_run;
   assign a1_if.runnable = a_run;
   assign a2_if.runnable = a_run;
   assign a0_if.nanci_result = a_rsp[0];
   assign a1_if.nanci_result = a_rsp[1];
   assign a2_if.nanci_result = a_rsp[2];
   assign a_req[0] = a0_if.app_request;
   assign a_req[1] = a1_if.app_request;
   assign a_req[2] = a2_if.app_request;
   assign a_done[0] = a0_if.done;
   assign a_done[1] = a1_if.done;
   assign a_done[2] = a2_if.done;
   assign a_iter[0] = a0_if.iter_count;
   assign a_iter[1] = a1_if.iter_count;
   assign a_iter[2] = a2_if.iter_count;
   assign a_cc[0] = a0_if.compute_cycles;
   assign a_cc[1] = a1_if.compute_cycles;
   assign a_cc[2] = a2_if.compute_cycles;

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model helpers ----------------
   function automatic int init_tgt(input int n, input int i, input int mode, input int stride);
      if (mode == 0) return n - 1 - i;
      if (mode == 1) return (i + 1) % n;
      return (i + stride) % n;
   endfunction

   function automatic int step_of(input int mode, input int stride);
      if (mode == 0) return 0;
      if (mode == 1) return 1;
      return stride;
   endfunction

   function automatic logic [MW-1:0] m_msg(input int w, input int a, input int d);
      return {w[0], MA'(a), MD'(d)};
   endfunction

   function automatic logic [AW-1:0] a_msg(input int w, input int a, input int d);
      return {w[0], AA'(a), AD'(d)};
   endfunction

   function automatic int m_tgt(input int k);
      return (M_I + M_STRIDE * (k + 1)) % M_N;
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- scoreboard state ----------------
   logic [MW-1:0] exp_q[$];

   int a_n[3], a_i[3], a_mode[3], a_stride[3], a_iters[3];
   int a_tgt[3], a_data[3], a_writes[3], a_rd_cyc[3];

   initial begin
      int  exp_cur;
      int  r;
      int  d;
      int  hold;
      int  cur;
      int  kind;
      int  m_data[M_ITERS];
      bit  pending;
      bit  done_t;
      bit  all_done;
      bit  first_seen;
      logic [MW-1:0] req;
      logic [MW-1:0] exp_req;

      n_checks = 0;
      n_fail = 0;
      rst_m = 1'b1;
      rst_a = 1'b1;
      a_run = 1'b0;
      for (int i = 0; i < 3; i++) a_rsp[i] = '0;
      m_if.runnable = 1'b0;
      m_if.nanci_result = '0;
      #1;
      rst_m = 1'b0;
      rst_a = 1'b0;
      tick();
      tick();

      // ===== auto-answered instances: one per target pattern =====
      a_n = '{1024, 8, 8};
      a_i = '{3, 7, 5};
      a_mode = '{0, 1, 2};
      a_stride = '{1, 1, 3};
      a_iters = '{4, 3, 4};
      for (int i = 0; i < 3; i++) begin
         check_eq($sformatf("aux%0d_rst_req", i), a_req[i], '0);
         check_eq($sformatf("aux%0d_rst_done", i), a_done[i], 0);
         check_eq($sformatf("aux%0d_rst_iter", i), a_iter[i], 0);
         check_eq($sformatf("aux%0d_cc", i), a_cc[i], 5);
         a_tgt[i] = init_tgt(a_n[i], a_i[i], a_mode[i], a_stride[i]);
         a_data[i] = (i == 0) ? 7 : $urandom_range(0, 1023);
         a_writes[i] = 0;
         a_rd_cyc[i] = -1;
         a_rsp[i] = a_msg(1, a_tgt[i], a_data[i]);
      end
      rst_a = 1'b1;
      a_run = 1'b1;
      all_done = 1'b0;
      for (int c = 0; c < 300 && !all_done; c++) begin
         tick();
         for (int i = 0; i < 3; i++) begin
            if (a_req[i][AW-1]) begin
               check_eq($sformatf("aux%0d_wr%0d", i, a_writes[i]), a_req[i],
                        a_msg(1, a_tgt[i], (a_data[i] + 1) % 1024));
               if (a_rd_cyc[i] >= 0)
                  check_eq($sformatf("aux%0d_rd2wr_lat", i), c - a_rd_cyc[i], 2);
               a_writes[i]++;
               a_tgt[i] = (a_tgt[i] + step_of(a_mode[i], a_stride[i])) % a_n[i];
               a_data[i] = (i == 0) ? 7 : $urandom_range(0, 1023);
               a_rd_cyc[i] = -1;
               a_rsp[i] = a_msg(1, a_tgt[i], a_data[i]);
            end else if (a_req[i] != '0) begin
               check_eq($sformatf("aux%0d_rd", i), a_req[i], a_msg(0, a_tgt[i], 0));
               a_rd_cyc[i] = c;
            end
         end
         all_done = 1'b1;
         for (int i = 0; i < 3; i++) if (a_writes[i] < a_iters[i]) all_done = 1'b0;
      end
      for (int k = 0; k < 3; k++) tick();
      for (int i = 0; i < 3; i++) begin
         check_eq($sformatf("aux%0d_writes", i), a_writes[i], a_iters[i]);
         check_eq($sformatf("aux%0d_done", i), a_done[i], 1);
         check_eq($sformatf("aux%0d_iter", i), a_iter[i], a_iters[i]);
         check_eq($sformatf("aux%0d_idle_req", i), a_req[i], '0);
      end
      a_run = 1'b0;

      // ===== main instance: reset values =====
      check_eq("m_rst_req", m_if.app_request, '0);
      check_eq("m_rst_done", m_if.done, 0);
      check_eq("m_rst_iter", m_if.iter_count, 0);
      check_eq("m_cc", m_if.compute_cycles, M_CC);

      // ===== timeout reissue, then a mismatched address, then an all-ones response =====
      rst_m = 1'b1;
      m_if.runnable = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         tick();
         exp_req = (k >= 2 && (k - 2) % M_TIMEOUT == 0) ? m_msg(0, 5, 0) : '0;
         check_eq($sformatf("tmo_req_k%0d", k), m_if.app_request, exp_req);
         if (k == 10) m_if.nanci_result = m_msg(1, 6, 55);
         if (k == 12) check_eq("mismatch_iter", m_if.iter_count, 0);
      end
      m_if.nanci_result = m_msg(1, 5, 1023);
      tick();
      check_eq("ones_wait", m_if.app_request, '0);
      m_if.nanci_result = '0;
      tick();
      check_eq("ones_wr_wrap", m_if.app_request, m_msg(1, 5, 0));
      check_eq("ones_iter", m_if.iter_count, 1);

      // ===== acceptance in the very cycle the timeout would fire =====
      d = $urandom_range(0, 1023);
      for (int k = 17; k <= 21; k++) begin
         if (k == 20) m_if.nanci_result = m_msg(1, 0, d);
         tick();
         if (k == 20) m_if.nanci_result = '0;
         exp_req = (k == 21) ? m_msg(1, 0, (d + 1) % 1024) : '0;
         check_eq($sformatf("coinc_req_k%0d", k), m_if.app_request, exp_req);
      end
      check_eq("coinc_iter", m_if.iter_count, 2);

      // ===== runnable toggling in RD_WAIT and WR_ISSUE (target 3) =====
      d = $urandom_range(0, 1023);
      r = 0;
      pending = 1'b0;
      done_t = 1'b0;
      hold = 0;
      exp_cur = 0;
      exp_req = m_msg(1, 0, 0);
      for (int i = 0; i < 120 && !done_t; i++) begin
         if (i == 24) m_if.nanci_result = m_msg(1, 3, d);
         if (pending && hold < 2) begin
            m_if.runnable = 1'b0;
            hold++;
         end else begin
            m_if.runnable = 1'($urandom_range(0, 1));
         end
         exp_cur = m_if.runnable;
         tick();
         if (exp_cur == 1) begin
            r++;
            if (pending) begin
               exp_req = m_msg(1, 3, (d + 1) % 1024);
               done_t = 1'b1;
            end else if ((r - 1) % M_TIMEOUT == 0) begin
               exp_req = m_msg(0, 3, 0);
            end else begin
               exp_req = '0;
               if (i >= 24) pending = 1'b1;
            end
         end
         check_eq($sformatf("tog_req_i%0d", i), m_if.app_request, exp_req);
         check_eq($sformatf("tog_iter_i%0d", i), m_if.iter_count, done_t ? 3 : 2);
      end
      check_eq("tog_completed", done_t, 1);
      m_if.nanci_result = '0;
      m_if.runnable = 1'b1;

      // ===== asynchronous reset in RD_WAIT (target 6) =====
      tick();
      check_eq("pre_rst_rd", m_if.app_request, m_msg(0, 6, 0));
      tick();
      check_eq("pre_rst_wait", m_if.app_request, '0);
      #3;
      rst_m = 1'b0;
      #1;
      check_eq("async_rst_req", m_if.app_request, '0);
      check_eq("async_rst_iter", m_if.iter_count, 0);
      check_eq("async_rst_done", m_if.done, 0);
      tick();
      check_eq("held_rst_req", m_if.app_request, '0);
      #2;
      rst_m = 1'b1;

      // ===== randomized full run after reset against the write scoreboard =====
      for (int k = 0; k < M_ITERS; k++) begin
         m_data[k] = (k == 2) ? 1023 : $urandom_range(0, 1023);
         exp_q.push_back(m_msg(1, m_tgt(k), (m_data[k] + 1) % 1024));
      end
      cur = 0;
      first_seen = 1'b0;
      for (int c = 0; c < 1500 && cur < M_ITERS; c++) begin
         kind = $urandom_range(0, 3);
         case (kind)
            0: m_if.nanci_result = m_msg(1, m_tgt(cur), m_data[cur]);
            1: m_if.nanci_result = m_msg(1, (m_tgt(cur) + 1 + $urandom_range(0, 6)) % M_N,
                                         $urandom_range(0, 1023));
            2: m_if.nanci_result = m_msg(0, m_tgt(cur), $urandom_range(0, 1023));
            default: m_if.nanci_result = '0;
         endcase
         m_if.runnable = ($urandom_range(0, 3) != 0);
         exp_cur = m_if.runnable;
         tick();
         if (exp_cur == 1) begin
            req = m_if.app_request;
            if (!first_seen && req != '0) begin
               check_eq("rst_first_rd", req, m_msg(0, 5, 0));
               first_seen = 1'b1;
            end
            if (req[MW-1]) begin
               if (exp_q.size() > 0) check_eq($sformatf("rnd_wr%0d", cur), req, exp_q.pop_front());
               else check_eq("rnd_extra_wr", req, '0);
               cur++;
            end else if (req != '0) begin
               check_eq($sformatf("rnd_rd%0d", cur), req, m_msg(0, m_tgt(cur), 0));
            end
         end
      end
      check_eq("rnd_q_left", exp_q.size(), 0);

      // DONE must absorb further responses
      m_if.runnable = 1'b1;
      m_if.nanci_result = m_msg(1, m_tgt(0), 5);
      for (int k = 0; k < 4; k++) begin
         tick();
         check_eq($sformatf("done_req_%0d", k), m_if.app_request, '0);
         check_eq($sformatf("done_flag_%0d", k), m_if.done, 1);
         check_eq($sformatf("done_iter_%0d", k), m_if.iter_count, M_ITERS);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
